ternary_neuron_seq: RTL and testbench

Parametrised sequential ternary-weight neuron: accumulates `N_INPUTS` signed activations times ternary weights, one pair per clock. It then adds a signed bias, saturates to `OUT_W` bits, applies a selectable activation and holds the result behind a valid/ready handshake. It is the generic replacement for the fixed-size per-layer neuron blocks. A layer controller instantiates it per output channel, or time-shares one instance, driving data for the index the block presents on `idx`.

---
 rtl/ternary_neuron_seq.sv | 155 +++++++++++++++
 tb/tb_ternary_neuron_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ternary_neuron_seq.sv
// Sequential ternary-weight neuron: one activation/weight pair per clock, then
// bias, output saturation and a selectable activation behind a valid/ready hold.
module ternary_neuron_seq #(
    parameter int unsigned N_INPUTS = 48,
    parameter int unsigned IN_W     = 2,
    parameter int unsigned ACC_W    = 8,
    parameter int unsigned BIAS_W   = 4,
    parameter int unsigned OUT_W    = 6,
    parameter int unsigned ACT_MODE = 0,
    localparam int unsigned IDX_W   = $clog2(N_INPUTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [BIAS_W-1:0] bias,
    input  logic [IN_W-1:0]   input_val,
    input  logic [1:0]        weight,
    output logic              busy,
    output logic [IDX_W-1:0]  idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  result,
    output logic              sat
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;

    localparam logic signed [SUM_W-1:0] ACC_MAX   = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN   = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX_N = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN_N = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [CMP_W-1:0] OUT_MAX   = CMP_W'(OUT_MAX_N);
    localparam logic signed [CMP_W-1:0] OUT_MIN   = CMP_W'(OUT_MIN_N);
    localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH, S_HOLD} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [BIAS_W-1:0]  r_bias;
    logic                      r_sticky;

    logic signed [IN_W-1:0]    w_in;
    logic signed [SUM_W-1:0]   w_in_ext;
    logic signed [SUM_W-1:0]   w_prod;
    logic signed [SUM_W-1:0]   w_acc_sum;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic                      w_acc_clip;
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [CMP_W-1:0]   w_sum_ext;
    logic signed [OUT_W-1:0]   w_r;
    logic                      w_out_clip;
    logic signed [OUT_W-1:0]   w_act;

    // Product is formed one bit wider than the accumulator so -min * -1 cannot wrap
    assign w_in     = input_val;
    assign w_in_ext = SUM_W'(w_in);

    always_comb begin
        w_prod = '0;
        case (weight)
            2'b01:   w_prod = w_in_ext;
            2'b11:   w_prod = -w_in_ext;
            default: w_prod = '0;
        endcase
    end

    always_comb begin
        w_acc_sum  = SUM_W'(r_acc) + w_prod;
        w_acc_clip = 1'b0;
        w_acc_next = ACC_W'(w_acc_sum);
        if (w_acc_sum > ACC_MAX) begin
            w_acc_next = ACC_W'(ACC_MAX);
            w_acc_clip = 1'b1;
        end else if (w_acc_sum < ACC_MIN) begin
            w_acc_next = ACC_W'(ACC_MIN);
            w_acc_clip = 1'b1;
        end
    end

    // Bias add, output clamp and activation, used in FINISH
    always_comb begin
        w_sum      = SUM_W'(r_acc) + SUM_W'(r_bias);
        w_sum_ext  = CMP_W'(w_sum);
        w_out_clip = 1'b0;
        w_r        = OUT_W'(w_sum_ext);
        if (w_sum_ext > OUT_MAX) begin
            w_r        = OUT_MAX_N;
            w_out_clip = 1'b1;
        end else if (w_sum_ext < OUT_MIN) begin
            w_r        = OUT_MIN_N;
            w_out_clip = 1'b1;
        end
        w_act = w_r;
        case (ACT_MODE)
            1:       w_act = w_r[OUT_W-1] ? {OUT_W{1'b1}} : OUT_W'(1);
            2:       w_act = w_r[OUT_W-1] ? '0 : w_r;
            default: w_act = w_r;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_ACCUM;
            S_ACCUM:  if (idx == IDX_LAST) w_next = S_FINISH;
            S_FINISH: w_next = S_HOLD;
            S_HOLD:   if (out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_bias    <= '0;
            r_sticky  <= 1'b0;
            busy      <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            sat       <= 1'b0;
        end else begin
            r_state   <= w_next;
            busy      <= (w_next == S_ACCUM) || (w_next == S_FINISH);
            out_valid <= (w_next == S_HOLD);
            if (!abort) begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_bias   <= bias;
                        r_acc    <= '0;
                        r_sticky <= 1'b0;
                        idx      <= '0;
                    end
                    S_ACCUM: begin
                        r_acc    <= w_acc_next;
                        r_sticky <= r_sticky | w_acc_clip;
                        if (idx != IDX_LAST) idx <= idx + IDX_W'(1);
                    end
                    S_FINISH: begin
                        result <= w_act;
                        sat    <= r_sticky | w_out_clip;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ternary_neuron_seq.sv
// Scoreboard bench: four neuron variants run in lockstep on shared directed vectors.
module tb_ternary_neuron_seq;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [3:0]       bias;
    logic [1:0]       input_val;
    logic [1:0]       weight;
    logic             out_ready;
    logic [3:0]       busy;
    logic [3:0]       valid;
    logic [3:0]       sat;
    logic [3:0][5:0]  idxs;
    logic [3:0][5:0]  res;

    logic [1:0]       mode;
    logic [1:0]       rnd [48];

    typedef struct packed {
        logic [3:0][5:0] res;
        logic [3:0]      sat;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_valid = 1'b0;

    ternary_neuron_seq #(.ACT_MODE(0)) d0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bias(bias),
        .input_val(input_val), .weight(weight), .busy(busy[0]), .idx(idxs[0]),
        .out_valid(valid[0]), .out_ready(out_ready), .result(res[0]), .sat(sat[0]));
    ternary_neuron_seq #(.ACT_MODE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bias(bias),
        .input_val(input_val), .weight(weight), .busy(busy[1]), .idx(idxs[1]),
        .out_valid(valid[1]), .out_ready(out_ready), .result(res[1]), .sat(sat[1]));
    ternary_neuron_seq #(.ACT_MODE(2)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bias(bias),
        .input_val(input_val), .weight(weight), .busy(busy[2]), .idx(idxs[2]),
        .out_valid(valid[2]), .out_ready(out_ready), .result(res[2]), .sat(sat[2]));
    ternary_neuron_seq #(.ACC_W(4)) d3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bias(bias),
        .input_val(input_val), .weight(weight), .busy(busy[3]), .idx(idxs[3]),
        .out_valid(valid[3]), .out_ready(out_ready), .result(res[3]), .sat(sat[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency data source keyed on the presented index
    always_comb begin
        input_val = 2'b01;
        weight    = 2'b01;
        case (mode)
            2'd1: begin input_val = idxs[0][0] ? 2'b11 : 2'b01; weight = 2'b11; end
            2'd2: begin input_val = rnd[idxs[0]];               weight = 2'b10; end
            2'd3: begin input_val = 2'b10;                      weight = 2'b11; end
            default: begin input_val = 2'b01;                   weight = 2'b01; end
        endcase
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [5:0] r0, input logic [5:0] r1,
                                input logic [5:0] r2, input logic [5:0] r3,
                                input logic [3:0] s);
        exp_t e;
        e.res[0] = r0;
        e.res[1] = r1;
        e.res[2] = r2;
        e.res[3] = r3;
        e.sat    = s;
        return e;
    endfunction

    function automatic logic [3:0] bias_of(input logic [1:0] m);
        case (m)
            2'd1:    return 4'b1101;
            2'd2:    return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    // Monitor: every rising out_valid must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && valid[0] && !prev_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("valid_d%0d", i), int'(valid[i]), 1);
                    chk($sformatf("result_d%0d", i), int'(res[i]), int'(e.res[i]));
                    chk($sformatf("sat_d%0d", i), int'(sat[i]), int'(e.sat[i]));
                end
            end
        end
        prev_valid = valid[0];
    end

    task automatic run_vec(input logic [1:0] m, input exp_t e);
        int cnt;
        mode  = m;
        bias  = bias_of(m);
        q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 1;
        while (!valid[0] && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("latency", cnt, 50);
        if (out_ready) begin
            tick();
            chk("valid_drop", int'(valid[0]), 0);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 48; i++) rnd[i] = 2'($urandom_range(0, 3));
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        mode = 2'd0; bias = 4'd0;
        repeat (3) tick();
        chk("rst_busy",   int'(busy[0]),  0);
        chk("rst_idx",    int'(idxs[0]),  0);
        chk("rst_valid",  int'(valid[0]), 0);
        chk("rst_result", int'(res[0]),   0);
        chk("rst_sat",    int'(sat[0]),   0);
        rst_n = 1'b1;
        tick();

        run_vec(2'd0, mk(6'd31, 6'd1, 6'd31, 6'd7, 4'b1111));
        run_vec(2'd1, mk(6'b111101, 6'b111111, 6'd0, 6'b111101, 4'b0000));
        run_vec(2'd2, mk(6'd5, 6'd1, 6'd5, 6'd5, 4'b0000));
        run_vec(2'd3, mk(6'd31, 6'd1, 6'd31, 6'd7, 4'b1111));

        // Abort mid-accumulation, then restart immediately
        mode = 2'd0; bias = 4'd0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (idxs[0] != 6'd20 && n < 100) begin tick(); n++; end
        chk("abort_reach_idx20", int'(idxs[0]), 20);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy",  int'(busy[0]),  0);
        chk("abort_valid", int'(valid[0]), 0);
        run_vec(2'd0, mk(6'd31, 6'd1, 6'd31, 6'd7, 4'b1111));

        // Back-pressure in HOLD with start pulses that must be ignored
        out_ready = 1'b0;
        run_vec(2'd1, mk(6'b111101, 6'b111111, 6'd0, 6'b111101, 4'b0000));
        mode = 2'd0; bias = 4'd0;
        for (int k = 0; k < 10; k++) begin
            start = k[0];
            tick();
            chk("hold_valid",  int'(valid[0]), 1);
            chk("hold_result", int'(res[0]),   int'(6'b111101));
            chk("hold_busy",   int'(busy[0]),  0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("hold_release_valid", int'(valid[0]), 0);
        tick();
        chk("hold_release_busy",  int'(busy[0]),  0);

        // Asynchronous reset mid-computation
        mode = 2'd0; bias = 4'd0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (idxs[0] != 6'd30 && n < 100) begin tick(); n++; end
        chk("reach_idx30", int'(idxs[0]), 30);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",   int'(busy[0]),  0);
        chk("arst_idx",    int'(idxs[0]),  0);
        chk("arst_valid",  int'(valid[0]), 0);
        chk("arst_result", int'(res[0]),   0);
        chk("arst_sat",    int'(sat[0]),   0);
        #1 rst_n = 1'b1;
        tick();

        run_vec(2'd2, mk(6'd5, 6'd1, 6'd5, 6'd5, 4'b0000));
        repeat (3) tick();
        chk("scoreboard_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
